// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler: state encoding, channel count, settle limits.
// No logic; imported by the sampler, its timer and its interface users.
// Not applicable: contains no handshakes.
package mux_scan_sampler_pkg;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef logic [1:0] ch_t;

    // Down-counter preload so that SETTLE lasts exactly `cycles` clocks.
    function automatic logic [CNT_W-1:0] settle_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Bundle of scan control, mux select/feedback and result handshake signals.
// master = sampler side, slave = environment (mux + consumer) side.
// valid/ready: data is held while valid && !ready.
interface mux_scan_sampler_if;
    logic       start;
    logic       cont;
    logic       mux_out;
    logic       s0;
    logic       s1;
    logic [3:0] data;
    logic       valid;
    logic       ready;
    logic       busy;

    modport master (
        input  start, cont, mux_out, ready,
        output s0, s1, data, valid, busy
    );

    modport slave (
        output start, cont, mux_out, ready,
        input  s0, s1, data, valid, busy
    );
endinterface

// File: rtl/mux_scan_sampler_settle_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Latency: load takes effect on the next edge; done is combinational from the count.
// No backpressure: load has priority over en.
module mux_scan_sampler_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps a 4:1 mux select through channels 0..3, samples after settling, emits a 4-bit word.
// Latency: valid rises 4*(SETTLE_CYCLES+1) edges after start is accepted.
// Backpressure: word and valid held in HOLD until ready; start ignored while busy.
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mux_scan_sampler_if.master     bus
);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("mux_scan_sampler: SETTLE_CYCLES out of range 1..15");
    end

    state_t     state_q, state_d;
    ch_t        ch_q, ch_d;
    logic [2:0] scratch_q, scratch_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       tmr_load;
    logic       tmr_done;

    mux_scan_sampler_settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (settle_load(SETTLE_CYCLES)),
        .en       (state_q == SETTLE),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        scratch_d = scratch_q;
        data_d    = data_q;
        valid_d   = valid_q;
        tmr_load  = 1'b0;

        case (state_q)
            IDLE: begin
                ch_d    = '0;
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d   = SETTLE;
                    scratch_d = '0;
                    tmr_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (ch_q != 2'd3) begin
                    for (int i = 0; i < NUM_CH - 1; i++) begin
                        if (ch_q == 2'(i)) begin
                            scratch_d[i] = bus.mux_out;
                        end
                    end
                    ch_d     = ch_q + 2'd1;
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                end else begin
                    // Last channel goes straight into the word; wrap to ch 0 here only.
                    data_d  = {bus.mux_out, scratch_q};
                    valid_d = 1'b1;
                    ch_d    = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    if (bus.cont) begin
                        state_d   = SETTLE;
                        ch_d      = '0;
                        scratch_d = '0;
                        tmr_load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            scratch_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            scratch_q <= scratch_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.s0    = ch_q[0];
    assign bus.s1    = ch_q[1];
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
